// File: rtl/hart_meter.sv
// hart_meter: counts debounced heartbeat pulses over WINDOW slow cycles and publishes a saturated 6-bit count on hart.
// hart/hart_valid update on the window-end edge (beat-to-accept latency 2 edges); no backpressure, clear_hart restarts.
module hart_meter #(
  parameter int WINDOW   = 60,
  parameter int DEBOUNCE = 4
) (
  input  logic       slow,
  input  logic       reset,
  input  logic       beat,
  input  logic       clear_hart,
  output logic [5:0] hart,
  output logic       hart_valid,
  output logic       saturated
);

  localparam logic [0:0]  ARMED     = 1'b0;
  localparam logic [0:0]  LOCKOUT   = 1'b1;
  localparam logic [11:0] WIN_LAST  = 12'(WINDOW - 1);
  localparam logic [7:0]  LOCK_INIT = 8'(DEBOUNCE - 1);
  localparam logic        LOCK_EN   = (DEBOUNCE > 1);
  localparam logic [6:0]  CNT_SAT   = 7'd64;
  localparam logic [6:0]  HART_MAX  = 7'd63;

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic [0:0]  state_q, state_d;
  logic [7:0]  lock_q, lock_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [11:0] win_q, win_d;
  logic [5:0]  hart_q, hart_d;
  logic        hart_valid_q, hart_valid_d;
  logic        saturated_q, saturated_d;
  logic        cand;
  logic        accept;
  logic [6:0]  total;

  // Rising edge of the synchronised beat; a held level yields a single candidate.
  assign cand = s2_q & ~s3_q;

  always_comb begin
    s1_d         = beat;
    s2_d         = s1_q;
    s3_d         = s2_q;
    state_d      = state_q;
    lock_d       = lock_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    hart_d       = hart_q;
    hart_valid_d = 1'b0;
    saturated_d  = saturated_q;
    accept       = 1'b0;
    total        = cnt_q;

    if (clear_hart) begin
      hart_d      = 6'd0;
      saturated_d = 1'b0;
      cnt_d       = 7'd0;
      win_d       = 12'd0;
      state_d     = ARMED;
      lock_d      = 8'd0;
    end else begin
      case (state_q)
        LOCKOUT: begin
          if (lock_q <= 8'd1) begin
            state_d = ARMED;
            lock_d  = 8'd0;
          end else begin
            lock_d = lock_q - 8'd1;
          end
        end
        default: begin
          if (cand) begin
            accept = 1'b1;
            if (LOCK_EN) begin
              state_d = LOCKOUT;
              lock_d  = LOCK_INIT;
            end
          end
        end
      endcase

      // A beat accepted on the window-end edge still belongs to the ending window.
      total = cnt_q + {6'd0, accept};

      if (win_q == WIN_LAST) begin
        hart_valid_d = 1'b1;
        if (total > HART_MAX) begin
          hart_d      = 6'd63;
          saturated_d = 1'b1;
        end else begin
          hart_d = total[5:0];
        end
        cnt_d = 7'd0;
        win_d = 12'd0;
      end else begin
        win_d = win_q + 12'd1;
        cnt_d = (total > CNT_SAT) ? CNT_SAT : total;
      end
    end
  end

  always_ff @(posedge slow) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      state_q      <= ARMED;
      lock_q       <= 8'd0;
      cnt_q        <= 7'd0;
      win_q        <= 12'd0;
      hart_q       <= 6'd0;
      hart_valid_q <= 1'b0;
      saturated_q  <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      state_q      <= state_d;
      lock_q       <= lock_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      hart_q       <= hart_d;
      hart_valid_q <= hart_valid_d;
      saturated_q  <= saturated_d;
    end
  end

  assign hart       = hart_q;
  assign hart_valid = hart_valid_q;
  assign saturated  = saturated_q;

endmodule

// File: tb/tb_hart_meter.sv
// Directed bench for hart_meter: one instance at WINDOW=60/DEBOUNCE=4, one at WINDOW=200/DEBOUNCE=1.
module tb_hart_meter;

  logic       slow = 1'b0;
  logic       reset_a, beat_a, clear_a;
  logic [5:0] hart_a;
  logic       valid_a, sat_a;
  logic       reset_b, beat_b, clear_b;
  logic [5:0] hart_b;
  logic       valid_b, sat_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 slow = ~slow;

  hart_meter #(.WINDOW(60), .DEBOUNCE(4)) u_dut_a (
    .slow(slow), .reset(reset_a), .beat(beat_a), .clear_hart(clear_a),
    .hart(hart_a), .hart_valid(valid_a), .saturated(sat_a)
  );

  hart_meter #(.WINDOW(200), .DEBOUNCE(1)) u_dut_b (
    .slow(slow), .reset(reset_b), .beat(beat_b), .clear_hart(clear_b),
    .hart(hart_b), .hart_valid(valid_b), .saturated(sat_b)
  );

  // After step n we sit 1 time unit past edge n: outputs reflect edge n, inputs set now are sampled at edge n+1.
  task automatic step;
    @(posedge slow);
    #1;
  endtask

  task automatic apply_reset_a;
    reset_a = 1'b1; beat_a = 1'b0; clear_a = 1'b0;
    step; step;
    reset_a = 1'b0;
  endtask

  task automatic test_reset;
    logic exp_v;
    reset_a = 1'b1; beat_a = 1'b0; clear_a = 1'b0;
    step; step;
    n_checks++;
    if ({hart_a, valid_a, sat_a} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got hart=%0d valid=%b sat=%b want 0/0/0", hart_a, valid_a, sat_a);
    end
    reset_a = 1'b0;
    for (int i = 1; i <= 180; i++) begin
      step;
      exp_v = (i % 60 == 0);
      n_checks++;
      if (valid_a !== exp_v) begin
        n_fail++;
        $display("FAIL reset_valid edge %0d: got %b want %b", i, valid_a, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (hart_a !== 6'd0 || sat_a !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_idle edge %0d: got hart=%0d sat=%b want 0/0", i, hart_a, sat_a);
        end
      end
    end
  endtask

  task automatic test_every5;
    apply_reset_a;
    for (int i = 1; i <= 120; i++) begin
      beat_a = ((i - 1) % 5 == 0) && (i <= 56);
      step;
      n_checks++;
      if (valid_a !== (i % 60 == 0)) begin
        n_fail++;
        $display("FAIL every5_valid edge %0d: got %b want %b", i, valid_a, (i % 60 == 0));
      end
      if (i >= 60 && i < 120) begin
        n_checks++;
        if (hart_a !== 6'd12) begin
          n_fail++;
          $display("FAIL every5_hart edge %0d: got %0d want 12", i, hart_a);
        end
      end
    end
    n_checks++;
    if (hart_a !== 6'd0) begin
      n_fail++;
      $display("FAIL every5_next_window: got %0d want 0", hart_a);
    end
    beat_a = 1'b0;
  endtask

  task automatic test_debounce;
    apply_reset_a;
    for (int i = 1; i <= 60; i++) begin
      beat_a = (i % 2 == 1);
      step;
    end
    beat_a = 1'b0;
    n_checks++;
    if (hart_a !== 6'd15 || valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL debounce_half: got hart=%0d valid=%b want 15/1", hart_a, valid_a);
    end
  endtask

  task automatic test_held_beat;
    apply_reset_a;
    beat_a = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      step;
      if (i == 60 || i == 120) begin
        n_checks++;
        if (hart_a !== ((i == 60) ? 6'd1 : 6'd0)) begin
          n_fail++;
          $display("FAIL held_beat edge %0d: got %0d want %0d", i, hart_a, (i == 60) ? 1 : 0);
        end
      end
    end
    beat_a = 1'b0;
  endtask

  task automatic test_clear;
    apply_reset_a;
    for (int i = 1; i <= 150; i++) begin
      beat_a  = (((i - 1) % 5 == 0) && i <= 56) || (i >= 61 && i <= 85 && (i - 61) % 4 == 0);
      clear_a = (i == 90);
      step;
      if (i == 60) begin
        n_checks++;
        if (hart_a !== 6'd12) begin
          n_fail++;
          $display("FAIL clear_pre: got %0d want 12", hart_a);
        end
      end
      if (i == 90) begin
        n_checks++;
        if (hart_a !== 6'd0 || sat_a !== 1'b0 || valid_a !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_now: got hart=%0d sat=%b valid=%b want 0/0/0", hart_a, sat_a, valid_a);
        end
      end
      if (i > 90) begin
        n_checks++;
        if (valid_a !== (i == 150)) begin
          n_fail++;
          $display("FAIL clear_valid edge %0d: got %b want %b", i, valid_a, (i == 150));
        end
      end
    end
    clear_a = 1'b0;
    beat_a  = 1'b0;
    n_checks++;
    if (hart_a !== 6'd0) begin
      n_fail++;
      $display("FAIL clear_discard: got %0d want 0", hart_a);
    end
  endtask

  task automatic test_boundary;
    apply_reset_a;
    for (int i = 1; i <= 180; i++) begin
      beat_a = (i == 58) || (i == 119);
      step;
      if (i % 60 == 0) begin
        n_checks++;
        if (hart_a !== ((i == 120) ? 6'd0 : 6'd1)) begin
          n_fail++;
          $display("FAIL boundary edge %0d: got %0d want %0d", i, hart_a, (i == 120) ? 0 : 1);
        end
      end
    end
    beat_a = 1'b0;
  endtask

  task automatic test_reset_midwindow;
    apply_reset_a;
    for (int i = 1; i <= 29; i++) begin
      beat_a = ((i - 1) % 4 == 0) && (i <= 9);
      step;
    end
    beat_a  = 1'b0;
    reset_a = 1'b1;
    step;
    reset_a = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      step;
      n_checks++;
      if (valid_a !== (i == 60)) begin
        n_fail++;
        $display("FAIL midreset_valid edge %0d: got %b want %b", i, valid_a, (i == 60));
      end
    end
    n_checks++;
    if (hart_a !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_discard: got %0d want 0", hart_a);
    end
  endtask

  task automatic test_saturate;
    reset_b = 1'b1; beat_b = 1'b0; clear_b = 1'b0;
    step; step;
    reset_b = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      beat_b = (i <= 198 && i % 2 == 1) || (i >= 211 && i <= 301 && (i - 211) % 10 == 0);
      step;
      if (i == 200) begin
        n_checks++;
        if (hart_b !== 6'd63 || sat_b !== 1'b1 || valid_b !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_window1: got hart=%0d sat=%b valid=%b want 63/1/1", hart_b, sat_b, valid_b);
        end
      end
      if (i == 300) begin
        n_checks++;
        if (hart_b !== 6'd63 || sat_b !== 1'b1 || valid_b !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_hold: got hart=%0d sat=%b valid=%b want 63/1/0", hart_b, sat_b, valid_b);
        end
      end
    end
    beat_b = 1'b0;
    n_checks++;
    if (hart_b !== 6'd10 || sat_b !== 1'b1 || valid_b !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_window2: got hart=%0d sat=%b valid=%b want 10/1/1", hart_b, sat_b, valid_b);
    end
  endtask

  initial begin
    reset_a = 1'b1; beat_a = 1'b0; clear_a = 1'b0;
    reset_b = 1'b1; beat_b = 1'b0; clear_b = 1'b0;
    test_reset;
    test_every5;
    test_debounce;
    test_held_beat;
    test_clear;
    test_boundary;
    test_reset_midwindow;
    test_saturate;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
